mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Arbitrates the single RAM address bus between two requesters: instruction fetch (PC) and data load/store (address register).
- Drives the select/enable of the RAM address mux, plus the RAM enable and write strobe.
- Sequences each access over a fixed RAM latency.
- Data has priority; a starvation guard guarantees fetch progress.

Parameters:
- RAM_LAT, 2, cycles each RAM access holds the bus (>=1).
- MAX_BURST, 3, max consecutive data grants while a fetch is pending (>=1).
- CW, 4, width of internal latency/burst counters; must hold max(RAM_LAT, MAX_BURST).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_f  input  1  fetch request; held high until done_f.
- req_d  input  1  data request; held high until done_d.
- we_d  input  1  data write (1) / read (0); valid while req_d is high.
- gnt_f  output  1  fetch owns bus.
- gnt_d  output  1  data owns bus.
- done_f  output  1  one-cycle pulse, final cycle of a fetch access.
- done_d  output  1  one-cycle pulse, final cycle of a data access.
- addr_sel  output  1  mux select/EN: 1 = data address, 0 = PC.
- ram_en  output  1  RAM enable.
- ram_we  output  1  RAM write strobe.
- busy  output  1  high in FETCH or DATA.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - All outputs = 0; addr_sel = 0 (PC).
  - lat_cnt = 0, burst_cnt = 0.
  - An in-flight access is abandoned and no done pulse is issued.
- All outputs are registered. States: IDLE, FETCH, DATA.
- IDLE: one arbitration cycle, evaluated at the rising edge.
  - req_d=1 and (req_f=0 or burst_cnt<MAX_BURST) -> DATA. Latch we_d. If req_f=1, burst_cnt++ (saturating at MAX_BURST); else burst_cnt=0.
  - else req_f=1 -> FETCH; burst_cnt=0.
  - else stay IDLE.
- FETCH: gnt_f=1, ram_en=1, addr_sel=0, ram_we=0, for exactly RAM_LAT cycles.
- DATA: gnt_d=1, ram_en=1, addr_sel=1, ram_we=latched we_d, for exactly RAM_LAT cycles. A change on we_d mid-access is ignored.
- lat_cnt loads RAM_LAT-1 on state entry and decrements each cycle.
- At lat_cnt=0 (final cycle): done_x=1 for that cycle only; next state = IDLE.
- Throughput: RAM_LAT+1 cycles per access; the IDLE gap is mandatory.
- Requester rule: clear req on the edge where done is sampled high. A req still high in the following IDLE cycle is a new request.
- Dropping req mid-access does not abort; the access completes and done still pulses.
- addr_sel is stable for the whole grant window and changes only on entry to FETCH/DATA. It holds its last value in IDLE.
- gnt_f and gnt_d are never both high; ram_en==busy==(gnt_f|gnt_d).
- Simultaneous req_f and req_d with burst_cnt<MAX_BURST: data wins.
- With burst_cnt=MAX_BURST: fetch wins, then the counter clears.

Test Plan:
- Reset, then req_f=1 at cycle 0 (RAM_LAT=2):
  - Required: gnt_f, ram_en high in cycles 1–2; addr_sel=0; done_f high in cycle 2 only.
  - IDLE in cycle 3, all low.
- req_d=1, we_d=1 alone:
  - Required: gnt_d, ram_en, ram_we, addr_sel=1 for 2 cycles; done_d on the second.
  - Toggling we_d mid-access leaves ram_we=1.
- req_f and req_d both held continuously, MAX_BURST=3:
  - Required: grant order D,D,D,F,D,D,D,F.
  - Each grant is 2 cycles followed by 1 IDLE cycle.
  - burst_cnt clears at each F.
- rst_n pulled low in the first cycle of a DATA access:
  - Required: all outputs 0 immediately, no done_d.
  - After release, a held req_d is re-granted from IDLE.
- req_d deasserted after its first grant cycle:
  - Required: access runs the full 2 cycles; done_d still pulses.
  - Next IDLE grants a pending req_f.
- Requester holds req_f high one cycle past done_f:
  - Required: a second full FETCH access is granted after the IDLE cycle.

Source files
------------

// File: rtl/mem_bus_if.sv
// mem_bus_if: handshake and RAM-control bundle shared between the two
// requesters (fetch and data) and the RAM address-bus arbiter.
//   req_f / req_d / we_d       : requester -> arbiter
//   gnt_f / gnt_d              : arbiter -> requesters, bus ownership
//   done_f / done_d            : arbiter -> requesters, last cycle of access
//   addr_sel / ram_en / ram_we : arbiter -> RAM address mux and RAM
//   busy                       : arbiter status, high while an access runs
// Modports: slave = arbiter side, master = requester/observer side.
`timescale 1ns/1ps
interface mem_bus_if;
    logic req_f;
    logic req_d;
    logic we_d;
    logic gnt_f;
    logic gnt_d;
    logic done_f;
    logic done_d;
    logic addr_sel;
    logic ram_en;
    logic ram_we;
    logic busy;

    modport slave (
        input  req_f, req_d, we_d,
        output gnt_f, gnt_d, done_f, done_d, addr_sel, ram_en, ram_we, busy
    );

    modport master (
        output req_f, req_d, we_d,
        input  gnt_f, gnt_d, done_f, done_d, addr_sel, ram_en, ram_we, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single RAM address bus between instruction
// fetch (PC) and data load/store (address register). Each access holds the
// bus for RAM_LAT cycles and is followed by one mandatory IDLE arbitration
// cycle. Data has priority, but after MAX_BURST consecutive data grants with
// a fetch waiting, the fetch is served so it can never starve.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; abandons any access, no done pulse
//   bus   : mem_bus_if.slave (requests in; grants, done pulses, RAM mux
//           select, RAM enable/write strobe and busy out, all registered)
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int RAM_LAT   = 2,
    parameter int MAX_BURST = 3,
    parameter int CW        = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_bus_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAT_LOAD  = CW'(RAM_LAT - 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
    // With a one-cycle access the entry cycle is also the final cycle.
    localparam logic          DONE_ON_ENTRY = (RAM_LAT == 1);

    state_t          state_reg;
    logic [CW-1:0]   lat_cnt_reg;
    logic [CW-1:0]   burst_cnt_reg;

    logic            data_wins;
    assign data_wins = bus.req_d && (!bus.req_f || (burst_cnt_reg < BURST_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lat_cnt_reg   <= '0;
            burst_cnt_reg <= '0;
            bus.gnt_f     <= 1'b0;
            bus.gnt_d     <= 1'b0;
            bus.done_f    <= 1'b0;
            bus.done_d    <= 1'b0;
            bus.addr_sel  <= 1'b0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (data_wins) begin
                        state_reg    <= DATA;
                        lat_cnt_reg  <= LAT_LOAD;
                        bus.gnt_d    <= 1'b1;
                        bus.ram_en   <= 1'b1;
                        bus.busy     <= 1'b1;
                        bus.addr_sel <= 1'b1;
                        // The write strobe register doubles as the latched
                        // we_d, so later changes on we_d have no effect.
                        bus.ram_we   <= bus.we_d;
                        bus.done_d   <= DONE_ON_ENTRY;
                        // Count data grants only while a fetch is waiting.
                        if (bus.req_f) begin
                            if (burst_cnt_reg < BURST_MAX) begin
                                burst_cnt_reg <= burst_cnt_reg + CW'(1);
                            end
                        end else begin
                            burst_cnt_reg <= '0;
                        end
                    end else if (bus.req_f) begin
                        state_reg     <= FETCH;
                        lat_cnt_reg   <= LAT_LOAD;
                        burst_cnt_reg <= '0;
                        bus.gnt_f     <= 1'b1;
                        bus.ram_en    <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.addr_sel  <= 1'b0;
                        bus.ram_we    <= 1'b0;
                        bus.done_f    <= DONE_ON_ENTRY;
                    end
                end

                FETCH, DATA: begin
                    if (lat_cnt_reg == '0) begin
                        // Final cycle has just ended: release the bus.
                        // addr_sel deliberately keeps its last value.
                        state_reg  <= IDLE;
                        bus.gnt_f  <= 1'b0;
                        bus.gnt_d  <= 1'b0;
                        bus.done_f <= 1'b0;
                        bus.done_d <= 1'b0;
                        bus.ram_en <= 1'b0;
                        bus.ram_we <= 1'b0;
                        bus.busy   <= 1'b0;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - CW'(1);
                        // Raise done one edge early so it is registered
                        // exactly in the cycle where lat_cnt reaches 0.
                        if (state_reg == FETCH) begin
                            bus.done_f <= (lat_cnt_reg == CW'(1));
                        end else begin
                            bus.done_d <= (lat_cnt_reg == CW'(1));
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int RAM_LAT   = 2;
    localparam int MAX_BURST = 3;
    localparam int CW        = 4;

    logic clk;
    logic rst_n;
    mem_bus_if bus();

    mem_bus_arbiter #(
        .RAM_LAT   (RAM_LAT),
        .MAX_BURST (MAX_BURST),
        .CW        (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cycle;

    // Output vector order: {gnt_f, gnt_d, done_f, done_d, addr_sel, ram_en, ram_we, busy}
    function automatic logic [7:0] mk(input logic gf, input logic gd, input logic df,
                                      input logic dd, input logic sel, input logic we);
        return {gf, gd, df, dd, sel, gf | gd, we, gf | gd};
    endfunction

    function automatic logic [7:0] actual();
        return {bus.gnt_f, bus.gnt_d, bus.done_f, bus.done_d,
                bus.addr_sel, bus.ram_en, bus.ram_we, bus.busy};
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = actual();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b (gf,gd,df,dd,sel,en,we,busy)",
                     name, cycle, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string      name;
        logic       rf;
        logic       rd;
        logic       wd;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rf, input logic rd,
                       input logic wd, input logic [7:0] exp);
        vec_t v;
        v.name = name; v.rf = rf; v.rd = rd; v.wd = wd; v.exp = exp;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // Schedule-based: on each arbitration decision the whole access (RAM_LAT
    // busy cycles plus the trailing IDLE cycle) is queued as expected outputs.
    logic [7:0] mq[$];
    int         m_burst;
    logic       m_sel;

    task automatic model_reset();
        mq.delete();
        m_burst = 0;
        m_sel   = 1'b0;
    endtask

    task automatic model_step(input logic rf, input logic rd, input logic wd,
                              output logic [7:0] exp);
        if (mq.size() == 0) begin
            if (rd && (!rf || m_burst < MAX_BURST)) begin
                for (int i = 0; i < RAM_LAT; i++)
                    mq.push_back(mk(0, 1, 0, i == RAM_LAT - 1, 1, wd));
                mq.push_back(mk(0, 0, 0, 0, 1, 0));
                m_sel = 1'b1;
                if (rf) m_burst = (m_burst < MAX_BURST) ? m_burst + 1 : m_burst;
                else    m_burst = 0;
            end else if (rf) begin
                for (int i = 0; i < RAM_LAT; i++)
                    mq.push_back(mk(1, 0, i == RAM_LAT - 1, 0, 0, 0));
                mq.push_back(mk(0, 0, 0, 0, 0, 0));
                m_sel   = 1'b0;
                m_burst = 0;
            end
        end
        if (mq.size() != 0) exp = mq.pop_front();
        else                exp = mk(0, 0, 0, 0, m_sel, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        cycle++;
        #1;
    endtask

    initial begin
        logic [7:0] e;
        checks = 0; failures = 0; cycle = 0;
        rst_n = 1'b0;
        bus.req_f = 1'b0; bus.req_d = 1'b0; bus.we_d = 1'b0;

        tick(); tick();
        check("reset_state", 8'h00);
        rst_n = 1'b1;

        // Each row: inputs seen at the next edge, outputs required after it.
        add("fetch_c1",        1, 0, 0, mk(1, 0, 0, 0, 0, 0));
        add("fetch_c2_done",   1, 0, 0, mk(1, 0, 1, 0, 0, 0));
        add("fetch_idle",      0, 0, 0, mk(0, 0, 0, 0, 0, 0));
        add("wr_c1",           0, 1, 1, mk(0, 1, 0, 0, 1, 1));
        add("wr_c2_we_toggle", 0, 1, 0, mk(0, 1, 0, 1, 1, 1));
        add("wr_idle_sel_hold",0, 0, 0, mk(0, 0, 0, 0, 1, 0));
        add("rd_c1",           0, 1, 0, mk(0, 1, 0, 0, 1, 0));
        add("rd_drop_c2_done", 1, 0, 0, mk(0, 1, 0, 1, 1, 0));
        add("rd_idle",         1, 0, 0, mk(0, 0, 0, 0, 1, 0));
        add("pend_fetch_c1",   1, 0, 0, mk(1, 0, 0, 0, 0, 0));
        add("pend_fetch_done", 1, 0, 0, mk(1, 0, 1, 0, 0, 0));
        add("held_req_idle",   1, 0, 0, mk(0, 0, 0, 0, 0, 0));
        add("refetch_c1",      1, 0, 0, mk(1, 0, 0, 0, 0, 0));
        add("refetch_done",    0, 0, 0, mk(1, 0, 1, 0, 0, 0));
        add("refetch_idle",    0, 0, 0, mk(0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            bus.req_f = vecs[i].rf; bus.req_d = vecs[i].rd; bus.we_d = vecs[i].wd;
            tick();
            check(vecs[i].name, vecs[i].exp);
        end

        // Both requesters held: grant order D,D,D,F repeating, 2 busy + 1 idle.
        bus.req_f = 1'b1; bus.req_d = 1'b1; bus.we_d = 1'b0;
        for (int k = 0; k < 24; k++) begin
            int  idx;
            int  ph;
            logic is_f;
            idx  = k / 3;
            ph   = k % 3;
            is_f = ((idx % 4) == 3);
            tick();
            if (ph < 2) e = mk(is_f, !is_f, is_f && ph == 1, !is_f && ph == 1, !is_f, 0);
            else        e = mk(0, 0, 0, 0, !is_f, 0);
            check($sformatf("burst_k%0d", k), e);
        end
        bus.req_f = 1'b0; bus.req_d = 1'b0;

        // Reset in the first DATA cycle: immediate clear, no done, then re-grant.
        bus.req_d = 1'b1; bus.we_d = 1'b1;
        tick();
        check("rst_data_c1", mk(0, 1, 0, 0, 1, 1));
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 8'h00);
        tick();
        check("rst_no_done", 8'h00);
        rst_n = 1'b1;
        tick();
        check("regrant_c1", mk(0, 1, 0, 0, 1, 1));
        tick();
        check("regrant_done", mk(0, 1, 0, 1, 1, 1));
        bus.req_d = 1'b0;
        tick();
        check("regrant_idle", mk(0, 0, 0, 0, 1, 0));

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic rf, rd, wd;
            @(posedge clk);
            rf = bus.req_f; rd = bus.req_d; wd = bus.we_d;
            cycle++;
            model_step(rf, rd, wd, e);
            #1;
            check($sformatf("random_c%0d", c), e);
            if (bus.done_f) $display("txn cycle=%0d fetch done", cycle);
            if (bus.done_d) $display("txn cycle=%0d data done we=%0b", cycle, bus.ram_we);

            if (bus.req_f && bus.done_f)      bus.req_f = ($urandom_range(0, 3) == 0);
            else if (bus.req_f && bus.gnt_f)  bus.req_f = ($urandom_range(0, 7) != 0);
            else if (!bus.req_f)              bus.req_f = ($urandom_range(0, 2) == 0);

            if (bus.req_d && bus.done_d)      bus.req_d = ($urandom_range(0, 3) == 0);
            else if (bus.req_d && bus.gnt_d)  bus.req_d = ($urandom_range(0, 7) != 0);
            else if (!bus.req_d)              bus.req_d = ($urandom_range(0, 1) == 0);

            bus.we_d = 1'($urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
